// File: rtl/rle_decompress_pkg.sv
// Shared types and constants for the run-length decompression scheduler.
package rle_decompress_pkg;

  localparam int BYTE_W = 8;
  localparam int RUN_W  = 8;
  localparam logic [2:0] MSB_BIT = 3'd7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    EXPAND = 3'd3,
    WRITE  = 3'd4,
    NEXT   = 3'd5,
    FLUSH  = 3'd6,
    DONE   = 3'd7
  } state_t;

endpackage

// File: rtl/rle_bit_packer.sv
// MSB-first bit accumulator: one bit per push, bit_idx counts 7 down to 0 and wraps.
module rle_bit_packer import rle_decompress_pkg::*; (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              clear_acc,
  input  logic              push,
  input  logic              bit_val,
  output logic [BYTE_W-1:0] acc,
  output logic [2:0]        bit_idx,
  output logic              full
);

  // clear restarts a job; clear_acc only empties the byte, keeping the bit position
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      bit_idx <= MSB_BIT;
    end else if (clear) begin
      acc     <= '0;
      bit_idx <= MSB_BIT;
    end else if (clear_acc) begin
      acc     <= '0;
    end else if (push) begin
      acc[bit_idx] <= bit_val;
      bit_idx      <= bit_idx - 3'd1;
    end
  end

  // the next push lands in bit 0 and completes the byte
  assign full = (bit_idx == 3'd0);

endmodule

// File: rtl/rle_decompress_scheduler.sv
// Fetches (in1,in2) code pairs over a single handshaked RAM port, expands them
// into bit runs and writes the packed bytes back through the same port.
module rle_decompress_scheduler import rle_decompress_pkg::*; #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [LEN_W-1:0]  src_pairs,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic [31:0]       out_byte_idx,
  output logic [2:0]        out_bit_idx,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata
);

  state_t             state, state_nx;
  logic [ADDR_W-1:0]  src_base_r, dst_base_r;
  logic [LEN_W-1:0]   pairs_r, pair_idx_r;
  logic               value_r;
  logic [RUN_W-1:0]   run_r;
  logic [31:0]        byte_idx_r;
  logic               busy_r, done_r;
  logic               pk_clear, pk_clear_acc, pk_push, pk_full;
  logic [BYTE_W-1:0]  pk_acc;
  logic [2:0]         pk_bit_idx;
  logic [ADDR_W-1:0]  pair_addr;

  rle_bit_packer u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (pk_clear),
    .clear_acc (pk_clear_acc),
    .push      (pk_push),
    .bit_val   (value_r),
    .acc       (pk_acc),
    .bit_idx   (pk_bit_idx),
    .full      (pk_full)
  );

  // next-state and packer strobes
  always_comb begin
    state_nx     = state;
    pk_clear     = 1'b0;
    pk_clear_acc = 1'b0;
    pk_push      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          pk_clear = 1'b1;
          state_nx = (src_pairs == '0) ? DONE : FETCH1;
        end else begin
          state_nx = IDLE;
        end
      end
      FETCH1: if (mem_ack) state_nx = FETCH2; else state_nx = FETCH1;
      FETCH2: begin
        if (mem_ack) state_nx = (mem_rdata == 8'd0) ? NEXT : EXPAND;
        else         state_nx = FETCH2;
      end
      EXPAND: begin
        pk_push = 1'b1;
        // a completed byte is written first even if the run ends on bit 0
        if (pk_full)                  state_nx = WRITE;
        else if (run_r == RUN_W'(1))  state_nx = NEXT;
        else                          state_nx = EXPAND;
      end
      WRITE: begin
        if (mem_ack) begin
          pk_clear_acc = 1'b1;
          state_nx     = (run_r != '0) ? EXPAND : NEXT;
        end else begin
          state_nx = WRITE;
        end
      end
      NEXT: begin
        if (pair_idx_r + LEN_W'(1) == pairs_r) state_nx = (pk_bit_idx != MSB_BIT) ? FLUSH : DONE;
        else                                   state_nx = FETCH1;
      end
      FLUSH:   if (mem_ack) state_nx = DONE; else state_nx = FLUSH;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign pair_addr = src_base_r + (ADDR_W'(pair_idx_r) << 1);

  // RAM port is a pure decode of the state register, so it is stable while a request waits
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = 8'd0;
    case (state)
      FETCH1: begin
        mem_req  = 1'b1;
        mem_addr = pair_addr;
      end
      FETCH2: begin
        mem_req  = 1'b1;
        mem_addr = pair_addr + ADDR_W'(1);
      end
      WRITE, FLUSH: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = dst_base_r + ADDR_W'(byte_idx_r);
        mem_wdata = pk_acc;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  // job registers, counters and status flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      src_base_r <= '0;
      dst_base_r <= '0;
      pairs_r    <= '0;
      pair_idx_r <= '0;
      value_r    <= 1'b0;
      run_r      <= '0;
      byte_idx_r <= 32'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state  <= state_nx;
      done_r <= (state == DONE);
      if (state == IDLE && start) busy_r <= 1'b1;
      else if (state == DONE)     busy_r <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            src_base_r <= src_base;
            dst_base_r <= dst_base;
            pairs_r    <= src_pairs;
            pair_idx_r <= '0;
            byte_idx_r <= 32'd0;
          end
        end
        FETCH1:       if (mem_ack) value_r <= mem_rdata[7];
        FETCH2:       if (mem_ack) run_r <= mem_rdata;
        EXPAND:       run_r <= run_r - RUN_W'(1);
        WRITE, FLUSH: if (mem_ack) byte_idx_r <= byte_idx_r + 32'd1;
        NEXT:         pair_idx_r <= pair_idx_r + LEN_W'(1);
        default:      run_r <= run_r;
      endcase
    end
  end

  assign busy         = busy_r;
  assign done         = done_r;
  assign out_byte_idx = byte_idx_r;
  assign out_bit_idx  = pk_bit_idx;

endmodule

// File: tb/tb_rle_decompress_scheduler.sv
// Scenario bench with a behavioural RAM responder and a write scoreboard.
module tb_rle_decompress_scheduler;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [15:0] src_base, src_pairs, dst_base;
  logic        busy, done;
  logic [31:0] out_byte_idx;
  logic [2:0]  out_bit_idx;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [0:65535];
  wr_t         exp_q[$];
  int          total = 0;
  int          bad = 0;
  int unsigned lat_max = 1;
  int          wait_cnt = -1;
  int          done_cnt = 0;
  int          rd_cnt = 0;
  int          req_cycles = 0;
  logic [15:0] req_addr;
  logic        req_we;
  logic [7:0]  req_wdata;

  rle_decompress_scheduler dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_base(src_base), .src_pairs(src_pairs),
    .dst_base(dst_base), .busy(busy), .done(done), .out_byte_idx(out_byte_idx),
    .out_bit_idx(out_bit_idx), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (mem_req === 1'b1) req_cycles++;
  end

  // RAM responder: random latency, request stability check, write scoreboard
  always @(negedge clk) begin
    if (rst_n !== 1'b1) begin
      mem_ack  = 1'b0;
      wait_cnt = -1;
    end else if (mem_ack) begin
      mem_ack  = 1'b0;
      wait_cnt = -1;
    end else if (mem_req === 1'b1) begin
      if (wait_cnt < 0) begin
        wait_cnt  = int'($urandom_range(lat_max, 1)) - 1;
        req_addr  = mem_addr;
        req_we    = mem_we;
        req_wdata = mem_wdata;
      end else begin
        total++;
        if ({mem_addr, mem_we, mem_wdata} !== {req_addr, req_we, req_wdata}) begin
          bad++;
          $display("FAIL req_stable: got addr=%h we=%b wdata=%h, held addr=%h we=%b wdata=%h",
                   mem_addr, mem_we, mem_wdata, req_addr, req_we, req_wdata);
        end
      end
      if (wait_cnt == 0) begin
        if (mem_we) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL write_expected: got write %h to %h, required no write", mem_wdata, mem_addr);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (mem_addr !== e.addr || mem_wdata !== e.data) begin
              bad++;
              $display("FAIL write_value: got %h @ %h, required %h @ %h", mem_wdata, mem_addr, e.data, e.addr);
            end
          end
          ram[mem_addr] = mem_wdata;
        end else begin
          mem_rdata = ram[mem_addr];
          rd_cnt++;
        end
        mem_ack = 1'b1;
      end else begin
        wait_cnt--;
      end
    end else begin
      wait_cnt = -1;
    end
  end

  task automatic load_pair(input logic [15:0] a, input logic [7:0] in1, input logic [7:0] in2);
    ram[a]          = in1;
    ram[a + 16'd1]  = in2;
  endtask

  task automatic expect_write(input logic [15:0] a, input logic [7:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  // launches a job and waits (bounded) for its done pulse
  task automatic run_job(input logic [15:0] s, input logic [15:0] n, input logic [15:0] d, output logic got);
    @(negedge clk);
    src_base = s; src_pairs = n; dst_base = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; src_base = 16'd0; src_pairs = 16'd0; dst_base = 16'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    total++; if (busy !== 1'b0)          begin bad++; $display("FAIL reset_busy: got %b required 0", busy); end
    total++; if (done !== 1'b0)          begin bad++; $display("FAIL reset_done: got %b required 0", done); end
    total++; if (mem_req !== 1'b0)       begin bad++; $display("FAIL reset_req: got %b required 0", mem_req); end
    total++; if (out_byte_idx !== 32'd0) begin bad++; $display("FAIL reset_byte_idx: got %0d required 0", out_byte_idx); end
    total++; if (out_bit_idx !== 3'd7)   begin bad++; $display("FAIL reset_bit_idx: got %0d required 7", out_bit_idx); end
    total++; if ({mem_we, mem_addr, mem_wdata} !== 25'd0) begin bad++; $display("FAIL reset_mem_bus: got %h required 0", {mem_we, mem_addr, mem_wdata}); end
  endtask

  task automatic test_single_byte();
    logic got;
    int d0;
    d0 = done_cnt;
    load_pair(16'h0010, 8'h80, 8'd8);
    expect_write(16'h0100, 8'hFF);
    run_job(16'h0010, 16'd1, 16'h0100, got);
    total++; if (got !== 1'b1)            begin bad++; $display("FAIL single_done: got timeout required done"); end
    total++; if (exp_q.size() != 0)       begin bad++; $display("FAIL single_writes: got %0d pending required 0", exp_q.size()); end
    total++; if (out_byte_idx !== 32'd1)  begin bad++; $display("FAIL single_byte_idx: got %0d required 1", out_byte_idx); end
    total++; if (out_bit_idx !== 3'd7)    begin bad++; $display("FAIL single_bit_idx: got %0d required 7", out_bit_idx); end
    total++; if (done_cnt - d0 != 1)      begin bad++; $display("FAIL single_done_cnt: got %0d required 1", done_cnt - d0); end
  endtask

  task automatic test_partial_flush();
    logic got;
    load_pair(16'h0020, 8'h80, 8'd3);
    load_pair(16'h0022, 8'h00, 8'd2);
    expect_write(16'h0180, 8'hE0);
    run_job(16'h0020, 16'd2, 16'h0180, got);
    total++; if (got !== 1'b1)           begin bad++; $display("FAIL flush_done: got timeout required done"); end
    total++; if (exp_q.size() != 0)      begin bad++; $display("FAIL flush_writes: got %0d pending required 0", exp_q.size()); end
    total++; if (out_byte_idx !== 32'd1) begin bad++; $display("FAIL flush_byte_idx: got %0d required 1", out_byte_idx); end
    total++; if (out_bit_idx !== 3'd2)   begin bad++; $display("FAIL flush_bit_idx: got %0d required 2", out_bit_idx); end
  endtask

  task automatic test_zero_pairs();
    int r0;
    r0 = req_cycles;
    @(negedge clk);
    src_base = 16'h0040; src_pairs = 16'd0; dst_base = 16'h0200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL zero_cycle1: got busy,done=%b required 10", {busy, done}); end
    @(negedge clk);
    total++; if ({busy, done} !== 2'b01) begin bad++; $display("FAIL zero_cycle2: got busy,done=%b required 01", {busy, done}); end
    @(negedge clk);
    total++; if (done !== 1'b0)          begin bad++; $display("FAIL zero_pulse: got done=%b required 0", done); end
    total++; if (req_cycles != r0)       begin bad++; $display("FAIL zero_no_req: got %0d req cycles required 0", req_cycles - r0); end
    total++; if (out_byte_idx !== 32'd0) begin bad++; $display("FAIL zero_byte_idx: got %0d required 0", out_byte_idx); end
  endtask

  task automatic test_zero_run();
    logic got;
    load_pair(16'h0050, 8'h80, 8'd0);
    load_pair(16'h0052, 8'h00, 8'd8);
    load_pair(16'h0060, 8'hFF, 8'd0);
    load_pair(16'h0062, 8'h7F, 8'd8);
    expect_write(16'h0300, 8'h00);
    run_job(16'h0050, 16'd2, 16'h0300, got);
    total++; if (got !== 1'b1)      begin bad++; $display("FAIL zrun_a_done: got timeout required done"); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL zrun_a_writes: got %0d pending required 0", exp_q.size()); end
    expect_write(16'h0310, 8'h00);
    run_job(16'h0060, 16'd2, 16'h0310, got);
    total++; if (got !== 1'b1)      begin bad++; $display("FAIL zrun_b_done: got timeout required done"); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL zrun_b_writes: got %0d pending required 0", exp_q.size()); end
    total++; if ({out_byte_idx, out_bit_idx} !== {32'd1, 3'd7}) begin bad++; $display("FAIL zrun_idx: got %0d/%0d required 1/7", out_byte_idx, out_bit_idx); end
  endtask

  task automatic test_stalls();
    logic got;
    lat_max = 5;
    load_pair(16'h0070, 8'h80, 8'd20);
    expect_write(16'h0400, 8'hFF);
    expect_write(16'h0401, 8'hFF);
    expect_write(16'h0402, 8'hF0);
    run_job(16'h0070, 16'd1, 16'h0400, got);
    lat_max = 1;
    total++; if (got !== 1'b1)           begin bad++; $display("FAIL stall_done: got timeout required done"); end
    total++; if (exp_q.size() != 0)      begin bad++; $display("FAIL stall_writes: got %0d pending required 0", exp_q.size()); end
    total++; if (out_byte_idx !== 32'd3) begin bad++; $display("FAIL stall_byte_idx: got %0d required 3", out_byte_idx); end
    total++; if (out_bit_idx !== 3'd3)   begin bad++; $display("FAIL stall_bit_idx: got %0d required 3", out_bit_idx); end
  endtask

  task automatic test_wrap_busy_start();
    logic got;
    int d0;
    d0 = done_cnt;
    load_pair(16'hFFFF, 8'h00, 8'd16);
    expect_write(16'hFFFF, 8'h00);
    expect_write(16'h0000, 8'h00);
    @(negedge clk);
    src_base = 16'hFFFF; src_pairs = 16'd1; dst_base = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    src_base = 16'h0010; src_pairs = 16'd5; dst_base = 16'h0500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    total++; if (got !== 1'b1)           begin bad++; $display("FAIL wrap_done: got timeout required done"); end
    total++; if (exp_q.size() != 0)      begin bad++; $display("FAIL wrap_writes: got %0d pending required 0", exp_q.size()); end
    total++; if (done_cnt - d0 != 1)     begin bad++; $display("FAIL wrap_done_cnt: got %0d required 1", done_cnt - d0); end
    total++; if (busy !== 1'b0)          begin bad++; $display("FAIL wrap_busy: got %b required 0", busy); end
    total++; if (out_byte_idx !== 32'd2) begin bad++; $display("FAIL wrap_byte_idx: got %0d required 2", out_byte_idx); end
  endtask

  task automatic test_reset_mid_expand();
    logic got;
    int d0, r0;
    d0 = done_cnt;
    r0 = rd_cnt;
    load_pair(16'h0090, 8'h80, 8'd40);
    @(negedge clk);
    src_base = 16'h0090; src_pairs = 16'd1; dst_base = 16'h0600; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rd_cnt - r0 >= 2 && mem_req === 1'b0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (got !== 1'b1) begin bad++; $display("FAIL abort_reach_expand: got timeout required expand"); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (mem_req !== 1'b0)     begin bad++; $display("FAIL abort_req: got %b required 0", mem_req); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL abort_busy: got %b required 0", busy); end
    total++; if (out_bit_idx !== 3'd7) begin bad++; $display("FAIL abort_bit_idx: got %0d required 7", out_bit_idx); end
    repeat (10) @(negedge clk);
    total++; if (done_cnt != d0)       begin bad++; $display("FAIL abort_no_done: got %0d done pulses required 0", done_cnt - d0); end
    load_pair(16'h00A0, 8'h80, 8'd9);
    expect_write(16'h0700, 8'hFF);
    expect_write(16'h0701, 8'h80);
    run_job(16'h00A0, 16'd1, 16'h0700, got);
    total++; if (got !== 1'b1)      begin bad++; $display("FAIL abort_rerun_done: got timeout required done"); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL abort_rerun_writes: got %0d pending required 0", exp_q.size()); end
    total++; if ({out_byte_idx, out_bit_idx} !== {32'd2, 3'd6}) begin bad++; $display("FAIL abort_rerun_idx: got %0d/%0d required 2/6", out_byte_idx, out_bit_idx); end
  endtask

  initial begin
    mem_ack = 1'b0;
    mem_rdata = 8'd0;
    for (int i = 0; i < 65536; i++) ram[i] = 8'd0;
    test_reset();
    test_single_byte();
    test_partial_flush();
    test_zero_pairs();
    test_zero_run();
    test_stalls();
    test_wrap_busy_start();
    test_reset_mid_expand();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
